// File: rtl/dma_task_seq.sv
// DMA task sequencer: issues one-hot init writes, an exec write, then
// waits for DMA completion with an optional timeout and a cycle profile.
module dma_task_seq #(
  parameter int DMA_INIT_TASK_CNT   = 4,
  parameter int DMA_EXEC_TASK_CNT   = 1,
  parameter int BANK1_STATUS_WIDTH  = 2,
  parameter int BANK1_PROFILE_WIDTH = 32,
  parameter int TIMEOUT_CYCLES      = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           dma_done,
  output logic [DMA_INIT_TASK_CNT-1:0]   slaveInit,
  input  logic [DMA_INIT_TASK_CNT-1:0]   slaveFinInit,
  output logic [DMA_EXEC_TASK_CNT-1:0]   slaveStartExec,
  input  logic [DMA_EXEC_TASK_CNT-1:0]   slaveStartExecAccept,
  output logic                           busy,
  output logic                           seq_done,
  output logic [BANK1_STATUS_WIDTH-1:0]  status,
  output logic [BANK1_PROFILE_WIDTH-1:0] profile
);

  localparam int N  = DMA_INIT_TASK_CNT;
  localparam int E  = DMA_EXEC_TASK_CNT;
  localparam int SW = BANK1_STATUS_WIDTH;
  localparam int PW = BANK1_PROFILE_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [PW-1:0] TMO_LAST =
    PW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic          TMO_EN   = (TIMEOUT_CYCLES != 0);

  localparam logic [SW-1:0] ST_IDLE = SW'(0);
  localparam logic [SW-1:0] ST_BUSY = SW'(1);
  localparam logic [SW-1:0] ST_OK   = SW'(2);
  localparam logic [SW-1:0] ST_TMO  = SW'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_EXEC,
    S_WAIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          bub_q, bub_d;
  logic [SW-1:0] status_q, status_d;
  logic [PW-1:0] profile_q, profile_d;

  logic [N-1:0]  init_req;
  logic          fin_hit;
  logic          tmo_hit;

  // Bubble flag gives the writer one idle cycle between init requests.
  assign init_req = (state_q == S_INIT && !bub_q)
                    ? (N'(1) << idx_q) : '0;
  assign fin_hit  = |(slaveFinInit & init_req);
  assign tmo_hit  = TMO_EN && (profile_q == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      bub_q     <= 1'b0;
      status_q  <= ST_IDLE;
      profile_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bub_q     <= bub_d;
      status_q  <= status_d;
      profile_q <= profile_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bub_d     = bub_q;
    status_d  = status_q;
    profile_d = profile_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d     = '0;
          bub_d     = 1'b0;
          profile_d = '0;
          status_d  = ST_BUSY;
          state_d   = S_INIT;
        end
      end
      S_INIT: begin
        if (bub_q) begin
          bub_d = 1'b0;
        end else if (fin_hit) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_EXEC;
          end else begin
            idx_d = idx_q + 1'b1;
            bub_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (slaveStartExecAccept[0]) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion outranks timeout; the done cycle is not counted.
        if (dma_done) begin
          status_d = ST_OK;
          state_d  = S_DONE;
        end else if (tmo_hit) begin
          status_d = ST_TMO;
          state_d  = S_DONE;
        end else if (!(&profile_q)) begin
          profile_d = profile_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    slaveInit      = init_req;
    slaveStartExec = (state_q == S_EXEC) ? E'(1) : '0;
    busy           = (state_q != S_IDLE);
    seq_done       = (state_q == S_DONE);
    status         = status_q;
    profile        = profile_q;
  end

endmodule

// File: tb/tb_dma_task_seq.sv
// Directed bench for dma_task_seq: three instances (no timeout,
// 8-cycle timeout, 4-bit profile) share stimulus and run in lockstep.
module tb_dma_task_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dma_done = 1'b0;
  logic [3:0] fin = '0;
  logic [0:0] acc = '0;

  logic [3:0]  si0, si1, si2;
  logic [0:0]  se0, se1, se2;
  logic        bz0, bz1, bz2;
  logic        sd0, sd1, sd2;
  logic [1:0]  st0, st1, st2;
  logic [31:0] pf0, pf1;
  logic [3:0]  pf2;

  int n_chk = 0;
  int n_pass = 0;
  int n_sd0 = 0;
  int n_sd1 = 0;

  always #5 clk = ~clk;

  dma_task_seq u0 (
    .clk(clk), .reset(reset), .start(start), .dma_done(dma_done),
    .slaveInit(si0), .slaveFinInit(fin),
    .slaveStartExec(se0), .slaveStartExecAccept(acc),
    .busy(bz0), .seq_done(sd0), .status(st0), .profile(pf0)
  );

  dma_task_seq #(.TIMEOUT_CYCLES(8)) u1 (
    .clk(clk), .reset(reset), .start(start), .dma_done(dma_done),
    .slaveInit(si1), .slaveFinInit(fin),
    .slaveStartExec(se1), .slaveStartExecAccept(acc),
    .busy(bz1), .seq_done(sd1), .status(st1), .profile(pf1)
  );

  dma_task_seq #(.BANK1_PROFILE_WIDTH(4)) u2 (
    .clk(clk), .reset(reset), .start(start), .dma_done(dma_done),
    .slaveInit(si2), .slaveFinInit(fin),
    .slaveStartExec(se2), .slaveStartExecAccept(acc),
    .busy(bz2), .seq_done(sd2), .status(st2), .profile(pf2)
  );

  always @(negedge clk) begin
    if (sd0) n_sd0++;
    if (sd1) n_sd1++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Entered on the first negedge a request is visible; ends on the bubble.
  task automatic init_task(input int i);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    chk("init_req", 32'(si0), 32'(oh));
    repeat (2) begin
      @(negedge clk);
      chk("init_hold", 32'(si0), 32'(oh));
    end
    @(negedge clk) fin = oh;
    @(negedge clk) fin = '0;
    chk("init_bubble", 32'(si0), 32'h0);
  endtask

  task automatic do_init();
    for (int i = 0; i < 4; i++) begin
      init_task(i);
      if (i < 3) @(negedge clk);
    end
  endtask

  task automatic do_exec();
    chk("exec_req", 32'(se0), 32'h1);
    repeat (2) @(negedge clk);
    @(negedge clk) acc = 1'b1;
    @(negedge clk) acc = 1'b0;
    chk("exec_drop", 32'(se0), 32'h0);
  endtask

  // d non-done WAIT cycles, then dma_done; returns on u0's DONE cycle.
  task automatic run_wait(input int d);
    repeat (d) @(negedge clk);
    dma_done = 1'b1;
    @(negedge clk) dma_done = 1'b0;
  endtask

  task automatic full_run(input int d);
    start_run();
    do_init();
    do_exec();
    run_wait(d);
  endtask

  int s0, s1;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_init", 32'(si0), 32'h0);
    chk("rst_exec", 32'(se0), 32'h0);
    chk("rst_busy", 32'(bz0), 32'h0);
    chk("rst_status", 32'(st0), 32'h0);
    chk("rst_profile", pf0, 32'h0);
    @(negedge clk) reset = 1'b0;

    s0 = n_sd0; s1 = n_sd1;
    full_run(10);
    chk("nom_seq_done", 32'(sd0), 32'h1);
    chk("nom_status", 32'(st0), 32'h2);
    chk("nom_profile", pf0, 32'd10);
    @(negedge clk);
    chk("nom_idle_busy", 32'(bz0), 32'h0);
    chk("nom_hold_status", 32'(st0), 32'h2);
    chk("nom_hold_profile", pf0, 32'd10);
    chk("nom_pulses", 32'(n_sd0 - s0), 32'd1);
    chk("tmo_status", 32'(st1), 32'h3);
    chk("tmo_profile", pf1, 32'd7);
    chk("tmo_busy", 32'(bz1), 32'h0);
    chk("tmo_pulses", 32'(n_sd1 - s1), 32'd1);
    chk("w4_profile", 32'(pf2), 32'd10);

    do_reset();
    full_run(7);
    chk("sim_status", 32'(st1), 32'h2);
    chk("sim_profile", pf1, 32'd7);
    chk("sim_seq_done", 32'(sd1), 32'h1);

    do_reset();
    full_run(20);
    chk("sat_status", 32'(st2), 32'h2);
    chk("sat_profile", 32'(pf2), 32'd15);
    chk("wide_profile", pf0, 32'd20);
    @(negedge clk);
    chk("sat_hold", 32'(pf2), 32'd15);

    do_reset();
    start_run();
    fin = 4'b0100; start = 1'b1; dma_done = 1'b1;
    @(negedge clk);
    fin = '0; start = 1'b0; dma_done = 1'b0;
    chk("fin_mismatch", 32'(si0), 32'h1);
    chk("ign_status", 32'(st0), 32'h1);
    @(negedge clk) fin = 4'b0001;
    @(negedge clk) fin = '0;
    chk("ign_bubble", 32'(si0), 32'h0);
    @(negedge clk);
    chk("ign_next", 32'(si0), 32'h2);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_ignored", 32'(si0), 32'h2);
    fin = 4'b0010;
    @(negedge clk) fin = '0;
    chk("ign_bubble2", 32'(si0), 32'h0);
    @(negedge clk);
    init_task(2);
    @(negedge clk);
    init_task(3);
    do_exec();
    run_wait(2);
    chk("ign_done_status", 32'(st0), 32'h2);
    chk("ign_done_profile", pf0, 32'd2);

    do_reset();
    start_run();
    init_task(0);
    @(negedge clk);
    init_task(1);
    @(negedge clk);
    chk("mid_req", 32'(si0), 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("async_init", 32'(si0), 32'h0);
    chk("async_busy", 32'(bz0), 32'h0);
    chk("async_status", 32'(st0), 32'h0);
    chk("async_exec", 32'(se0), 32'h0);
    chk("async_seq_done", 32'(sd0), 32'h0);
    @(negedge clk) reset = 1'b0;
    full_run(3);
    chk("rerun_status", 32'(st0), 32'h2);
    chk("rerun_profile", pf0, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dma_task_seq.md
DMA_TASK_SEQ -- requirements
Module: dma_task_seq

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- DMA_INIT_TASK_CNT, 4, number of one-hot init tasks (src addr, src size, des addr, des size).
- DMA_EXEC_TASK_CNT, 1, number of exec-start tasks.
- BANK1_STATUS_WIDTH, 2, status field width.
- BANK1_PROFILE_WIDTH, 32, profile counter width.
- TIMEOUT_CYCLES, 0, WAIT-state timeout in cycles; 0 disables the timeout.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock; all logic on rising edge.
- reset, in, 1, asynchronous, active-high reset.
- start, in, 1, single-cycle request to run one DMA transfer.
- dma_done, in, 1, DMA completion indication (level or pulse).
- slaveInit, out, DMA_INIT_TASK_CNT, one-hot init task request to the AXI-Lite writer.
- slaveFinInit, in, DMA_INIT_TASK_CNT, writer's per-task completion strobe.
- slaveStartExec, out, DMA_EXEC_TASK_CNT, exec (control register write) request.
- slaveStartExecAccept, in, DMA_EXEC_TASK_CNT, writer's exec-write completion strobe.
- busy, out, 1, high in any state other than IDLE.
- seq_done, out, 1, single-cycle pulse at the end of each run.
- status, out, BANK1_STATUS_WIDTH, 00 idle/never run, 01 busy, 10 done OK, 11 timeout.
- profile, out, BANK1_PROFILE_WIDTH, cycle count of the last WAIT phase.
REQ-003 The clock and reset SHALL be a single clock with asynchronous, active-high reset, exactly as named above.

Function
REQ-004 The FSM SHALL have the states IDLE, INIT, EXEC, WAIT and DONE, plus a task index idx of width clog2(DMA_INIT_TASK_CNT).
REQ-005 IDLE: start=1 SHALL set idx=0, clear profile to 0, set status=01, and move to INIT. start SHALL be ignored in every other state.
REQ-006 INIT: slaveInit SHALL equal 1<<idx, held stable until completion, and all other outputs SHALL be unchanged.
REQ-007 INIT completion: the task completes when (slaveFinInit & slaveInit) != 0. On completion, idx SHALL increment; if idx was DMA_INIT_TASK_CNT-1, the next state SHALL be EXEC.
REQ-008 On the cycle after each completion, slaveInit SHALL be 0 (one bubble), so the writer sees a fresh request; the next one-hot value SHALL be driven the cycle after that.
REQ-009 A slaveFinInit bit that does not match the current slaveInit SHALL be ignored.
REQ-010 EXEC: slaveStartExec[0] SHALL be 1, and slaveInit SHALL be 0. When slaveStartExecAccept[0]=1, the next state SHALL be WAIT and slaveStartExec SHALL be 0 from the next cycle.
REQ-011 WAIT: profile SHALL increment by 1 each cycle and saturate at all-ones with no wrap.
- dma_done=1 SHALL move the FSM to DONE with status=10. The profile value SHALL exclude the dma_done cycle.
REQ-012 WAIT timeout: if TIMEOUT_CYCLES != 0 and profile reaches TIMEOUT_CYCLES-1 with dma_done=0, the next state SHALL be DONE with status=11.
- If dma_done and the timeout occur in the same cycle, dma_done SHALL win (status=10).
REQ-013 DONE SHALL last exactly 1 cycle with seq_done=1, then return to IDLE.
- status and profile SHALL hold their values until the next accepted start.
REQ-014 Worst-case latency from start to first slaveInit SHALL be 1 cycle; there is no other hidden latency.
REQ-015 dma_done asserted outside WAIT SHALL be ignored.

Reset
REQ-016 reset=1 at any time, including mid-handshake, SHALL immediately force:
- the FSM to IDLE and idx=0;
- slaveInit=0, slaveStartExec=0, busy=0, seq_done=0, status=00, profile=0.
REQ-017 After reset deassertion, the first start SHALL be accepted at the first clk edge where it is sampled high.

Verification
REQ-018 Nominal run: pulse start; writer returns each FinInit 3 cycles after request; accept exec after 3 cycles; dma_done 10 cycles into WAIT.
- slaveInit sequence 0001, 0010, 0100, 1000, each separated by a zero bubble.
- Then one exec request, profile=10, status=10, one seq_done pulse.
REQ-019 Timeout: TIMEOUT_CYCLES=8, dma_done never asserted -> status=11, profile=7, seq_done pulse, busy low afterwards.
REQ-020 Simultaneous events: TIMEOUT_CYCLES=8 with dma_done on the 8th WAIT cycle -> status=10, not 11.
REQ-021 Ignored inputs:
- start pulsed during INIT -> no restart, idx continues.
- slaveFinInit=0100 while slaveInit=0001 -> no advance.
REQ-022 Reset mid-run: assert reset while slaveInit=0100 -> all outputs 0 on the same cycle (asynchronous).
- A new start then runs the full sequence again from 0001.
REQ-023 Saturation: BANK1_PROFILE_WIDTH=4 with dma_done after 20 WAIT cycles -> profile=15, status=10.
